// File: rtl/scan_memory.sv
// scan_memory: unified instruction/data memory with a configurable-latency
// ready handshake on the CPU port and a background min/max scan engine that
// reads through its own combinational port while CPU accesses continue.
module scan_memory #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned SCAN_BASE = 1000,
  parameter int unsigned SCAN_LEN  = 20,
  parameter int unsigned MODE      = 0,
  parameter int unsigned SIGNED    = 1,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_data_adr,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [DATA_W-1:0] mem_out,
  output logic              ready,
  input  logic              scan_start,
  output logic              scan_busy,
  output logic              scan_done,
  output logic [DATA_W-1:0] min_value,
  output logic [31:0]       min_index
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned CW        = $clog2(LATENCY + 1);
  localparam logic [31:0] BASE_WORD = 32'(SCAN_BASE / 4);
  localparam logic [31:0] LAST_K    = 32'(SCAN_LEN - 1);

  typedef enum logic {IDLE, BUSY}    cpu_state_t;
  typedef enum logic {S_IDLE, S_RUN} scan_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  // CPU port state
  cpu_state_t        cpu_state;
  logic [CW-1:0]     cnt;
  logic [AW-1:0]     lat_idx;
  logic [DATA_W-1:0] lat_data;
  logic              lat_write;
  logic [AW-1:0]     in_idx;
  logic              commit_we;

  // Scan engine state
  scan_state_t       scan_state;
  logic [31:0]       k;
  logic [DATA_W-1:0] acc_val;
  logic [31:0]       acc_idx;
  logic [AW-1:0]     scan_idx;
  logic [DATA_W-1:0] scan_word;
  logic              better;
  logic              take;

  logic              unused_adr_bits;

  assign in_idx          = inst_data_adr[AW+1:2];
  assign unused_adr_bits = ^{inst_data_adr[31:AW+2], inst_data_adr[1:0]};

  // Write commits on the edge that ends the final BUSY cycle of a write
  assign commit_we = (cpu_state == BUSY) && (cnt == CW'(1)) && lat_write;

  // Array write port; gated by reset so an in-flight write is discarded
  always_ff @(posedge clk) begin
    if (!rst && commit_we) mem[lat_idx] <= lat_data;
  end

  // CPU access FSM; ready and mem_out are registered one edge ahead of the
  // final BUSY cycle so they are valid throughout that cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_state <= IDLE;
      cnt       <= '0;
      lat_idx   <= '0;
      lat_data  <= '0;
      lat_write <= 1'b0;
      ready     <= 1'b0;
      mem_out   <= '0;
    end else begin
      case (cpu_state)
        IDLE: begin
          ready <= 1'b0;
          if (mem_read || mem_write) begin
            lat_idx   <= in_idx;
            lat_data  <= mem_data_in;
            lat_write <= mem_write;
            cnt       <= CW'(LATENCY);
            cpu_state <= BUSY;
            if (LATENCY == 1) begin
              ready <= 1'b1;
              if (!mem_write) mem_out <= mem[in_idx];
            end
          end
        end
        BUSY: begin
          if (cnt == CW'(1)) begin
            cpu_state <= IDLE;
            ready     <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(2)) begin
              ready <= 1'b1;
              if (!lat_write) mem_out <= mem[lat_idx];
            end
          end
        end
        default: cpu_state <= IDLE;
      endcase
    end
  end

  // Scan read port: combinational, wraps modulo DEPTH
  assign scan_idx  = AW'(BASE_WORD + k);
  assign scan_word = mem[scan_idx];

  // Strictly-better compare against the accumulator
  always_comb begin
    better = 1'b0;
    if (SIGNED != 0) begin
      if (MODE != 0) better = $signed(scan_word) > $signed(acc_val);
      else           better = $signed(scan_word) < $signed(acc_val);
    end else begin
      if (MODE != 0) better = scan_word > acc_val;
      else           better = scan_word < acc_val;
    end
  end

  assign take = (k == '0) || better;

  // Scan FSM; the last element is folded straight into the result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_state <= S_IDLE;
      k          <= '0;
      acc_val    <= '0;
      acc_idx    <= '0;
      scan_busy  <= 1'b0;
      scan_done  <= 1'b0;
      min_value  <= '0;
      min_index  <= '0;
    end else begin
      case (scan_state)
        S_IDLE: begin
          scan_done <= 1'b0;
          if (scan_start) begin
            scan_state <= S_RUN;
            k          <= '0;
            acc_val    <= '0;
            acc_idx    <= '0;
            scan_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (take) begin
            acc_val <= scan_word;
            acc_idx <= k;
          end
          if (k == LAST_K) begin
            min_value  <= take ? scan_word : acc_val;
            min_index  <= take ? k : acc_idx;
            scan_done  <= 1'b1;
            scan_busy  <= 1'b0;
            scan_state <= S_IDLE;
          end else begin
            k <= k + 32'd1;
          end
        end
        default: scan_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_memory.sv
// Scoreboard bench for scan_memory: stimulus pushes expected responses into
// queues, a negedge monitor pops and compares on ready / scan_done.
module tb_scan_memory;

  localparam int unsigned LAT = 3;
  localparam int unsigned SL  = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_data_adr = '0;
  logic [31:0] mem_data_in = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        scan_start = 1'b0;

  logic [31:0] mem_out0, mem_out1, mem_out2;
  logic        ready0, ready1, ready2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic [31:0] val0, val1, val2;
  logic [31:0] idx0, idx1, idx2;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_err = 0;
  int unsigned busy_cnt = 0;

  typedef struct {
    int unsigned cyc;
    logic [31:0] mo;
  } cpu_exp_t;

  typedef struct {
    int unsigned cyc;
    logic [31:0] v0, v1, v2;
    logic [31:0] i0, i1, i2;
  } scan_exp_t;

  cpu_exp_t  cpu_q [$];
  scan_exp_t scan_q [$];

  logic [31:0] region [5];

  // Signed minimum
  scan_memory #(
    .DATA_W(32), .DEPTH(256), .LATENCY(LAT), .SCAN_BASE(1000),
    .SCAN_LEN(SL), .MODE(0), .SIGNED(1), .INIT_FILE("")
  ) u_min_s (
    .clk(clk), .rst(rst), .inst_data_adr(inst_data_adr), .mem_data_in(mem_data_in),
    .mem_read(mem_read), .mem_write(mem_write), .mem_out(mem_out0), .ready(ready0),
    .scan_start(scan_start), .scan_busy(busy0), .scan_done(done0),
    .min_value(val0), .min_index(idx0)
  );

  // Unsigned minimum
  scan_memory #(
    .DATA_W(32), .DEPTH(256), .LATENCY(LAT), .SCAN_BASE(1000),
    .SCAN_LEN(SL), .MODE(0), .SIGNED(0), .INIT_FILE("")
  ) u_min_u (
    .clk(clk), .rst(rst), .inst_data_adr(inst_data_adr), .mem_data_in(mem_data_in),
    .mem_read(mem_read), .mem_write(mem_write), .mem_out(mem_out1), .ready(ready1),
    .scan_start(scan_start), .scan_busy(busy1), .scan_done(done1),
    .min_value(val1), .min_index(idx1)
  );

  // Signed maximum
  scan_memory #(
    .DATA_W(32), .DEPTH(256), .LATENCY(LAT), .SCAN_BASE(1000),
    .SCAN_LEN(SL), .MODE(1), .SIGNED(1), .INIT_FILE("")
  ) u_max_s (
    .clk(clk), .rst(rst), .inst_data_adr(inst_data_adr), .mem_data_in(mem_data_in),
    .mem_read(mem_read), .mem_write(mem_write), .mem_out(mem_out2), .ready(ready2),
    .scan_start(scan_start), .scan_busy(busy2), .scan_done(done2),
    .min_value(val2), .min_index(idx2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares DUT responses against the queued expectations
  always @(negedge clk) begin : mon
    cpu_exp_t  ce;
    scan_exp_t se;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy0) busy_cnt++;
      if (ready0) begin
        if (cpu_q.size() == 0) begin
          chk("unexpected_ready", 32'd1, 32'd0);
        end else begin
          ce = cpu_q.pop_front();
          chk("ready_cycle", cyc, ce.cyc);
          chk("mem_out", mem_out0, ce.mo);
          chk("mem_out_u", mem_out1, ce.mo);
        end
      end
      if (done0) begin
        if (scan_q.size() == 0) begin
          chk("unexpected_scan_done", 32'd1, 32'd0);
        end else begin
          se = scan_q.pop_front();
          chk("done_cycle", cyc, se.cyc);
          chk("busy_cycles", busy_cnt, SL);
          chk("min_s_value", val0, se.v0);
          chk("min_s_index", idx0, se.i0);
          chk("min_u_done", {31'd0, done1}, 32'd1);
          chk("min_u_value", val1, se.v1);
          chk("min_u_index", idx1, se.i1);
          chk("max_s_done", {31'd0, done2}, 32'd1);
          chk("max_s_value", val2, se.v2);
          chk("max_s_index", idx2, se.i2);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (cpu_q.size() == 0 && scan_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_timeout", 32'(cpu_q.size() + scan_q.size()), 32'd0);
    cpu_q.delete();
    scan_q.delete();
  endtask

  task automatic cpu_access(input logic rd, input logic wr, input logic [31:0] adr,
                            input logic [31:0] data, input logic [31:0] exp_mo);
    cpu_exp_t e;
    @(negedge clk);
    mem_read      = rd;
    mem_write     = wr;
    inst_data_adr = adr;
    mem_data_in   = data;
    e.cyc = cyc + LAT;
    e.mo  = exp_mo;
    cpu_q.push_back(e);
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    drain();
  endtask

  task automatic push_scan(input int unsigned c, input logic [31:0] v0, input logic [31:0] i0,
                           input logic [31:0] v1, input logic [31:0] i1,
                           input logic [31:0] v2, input logic [31:0] i2);
    scan_exp_t s;
    s.cyc = c + 1 + SL;
    s.v0 = v0; s.i0 = i0;
    s.v1 = v1; s.i1 = i1;
    s.v2 = v2; s.i2 = i2;
    scan_q.push_back(s);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    region[0] = 32'd5;
    region[1] = 32'hFFFF_FFFD;
    region[2] = 32'd7;
    region[3] = 32'hFFFF_FFFD;
    region[4] = 32'd0;

    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, ready0}, 32'd0);
    chk("rst_mem_out", mem_out0, 32'd0);
    chk("rst_scan_busy", {31'd0, busy0}, 32'd0);
    chk("rst_scan_done", {31'd0, done0}, 32'd0);
    chk("rst_min_value", val0, 32'd0);
    chk("rst_min_index", idx0, 32'd0);
    rst = 1'b0;

    // Basic write/read, latency and mem_out hold behaviour
    cpu_access(1'b0, 1'b1, 32'd1000, 32'h1234, 32'h0);
    cpu_access(1'b1, 1'b0, 32'd1000, 32'h0,    32'h1234);
    cpu_access(1'b0, 1'b1, 32'd8,    32'hDEAD, 32'h1234);
    cpu_access(1'b1, 1'b0, 32'd8,    32'h0,    32'hDEAD);
    cpu_access(1'b1, 1'b1, 32'd12,   32'h55,   32'hDEAD);
    cpu_access(1'b1, 1'b0, 32'd12,   32'h0,    32'h55);

    // Load the scan region {5, -3, 7, -3, 0}
    for (int i = 0; i < 5; i++)
      cpu_access(1'b0, 1'b1, 32'd1000 + 32'(4 * i), region[i], 32'h55);

    // Scan with a concurrent write of -100 to element 0 and a stray start pulse
    @(negedge clk);
    scan_start    = 1'b1;
    mem_write     = 1'b1;
    inst_data_adr = 32'd1000;
    mem_data_in   = 32'hFFFF_FF9C;
    push_scan(cyc, 32'hFFFF_FFFD, 32'd1, 32'd0, 32'd4, 32'd7, 32'd2);
    begin
      cpu_exp_t e;
      e.cyc = cyc + LAT;
      e.mo  = 32'h55;
      cpu_q.push_back(e);
    end
    @(negedge clk);
    scan_start = 1'b0;
    mem_write  = 1'b0;
    @(negedge clk);
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    chk("hold_min_value", val0, 32'hFFFF_FFFD);

    // Reset during a pending write to word 2 and mid-scan
    @(negedge clk);
    mem_write     = 1'b1;
    inst_data_adr = 32'd8;
    mem_data_in   = 32'hBEEF;
    scan_start    = 1'b1;
    @(negedge clk);
    mem_write  = 1'b0;
    scan_start = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, ready0}, 32'd0);
    chk("midrst_mem_out", mem_out0, 32'd0);
    chk("midrst_scan_busy", {31'd0, busy0}, 32'd0);
    chk("midrst_scan_done", {31'd0, done0}, 32'd0);
    chk("midrst_min_value", val0, 32'd0);
    chk("midrst_min_index", idx0, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Recovery: old word survives, new scan sees the -100 written earlier
    cpu_access(1'b1, 1'b0, 32'd8, 32'h0, 32'hDEAD);
    @(negedge clk);
    scan_start = 1'b1;
    push_scan(cyc, 32'hFFFF_FF9C, 32'd0, 32'd0, 32'd4, 32'd7, 32'd2);
    @(negedge clk);
    scan_start = 1'b0;
    drain();
    cpu_access(1'b1, 1'b0, 32'd1000, 32'h0, 32'hFFFF_FF9C);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/scan_memory.md
# scan_memory

Parametrised, handshaked successor to the multicycle MIPS unified instruction/data memory. It adds configurable word width, depth and access latency, with a `ready` handshake so the CPU controller can stall on slow memory. It also adds a background scan engine that finds the minimum or maximum of a fixed array region while CPU accesses continue. It sits between the `mips` core and the top-level bench/SoC as a drop-in memory.

## Interface
- `DATA_W`, 32: word width in bits.
- `DEPTH`, 1024: number of words; power of two.
- `LATENCY`, 2: cycles from request acceptance to `ready`; must be ≥1.
- `SCAN_BASE`, 1000: byte address of scan element 0; word aligned.
- `SCAN_LEN`, 20: number of words scanned; must be ≥1.
- `MODE`, 0: 0 = find minimum, 1 = find maximum.
- `SIGNED`, 1: 1 = two's-complement compare, 0 = unsigned.
- `INIT_FILE`, "": hex image loaded by `$readmemh` at time 0 when non-empty.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `inst_data_adr`  in  32  byte address; word index = `inst_data_adr[log2(DEPTH)+1:2]`; bits [1:0] and the upper bits are ignored.
- `mem_data_in`  in  `DATA_W`  write data.
- `mem_read`  in  1  read request, level.
- `mem_write`  in  1  write request, level.
- `mem_out`  out  `DATA_W`  read data.
- `ready`  out  1  one-cycle completion pulse.
- `scan_start`  in  1  starts a scan.
- `scan_busy`  out  1  high while the scan is running.
- `scan_done`  out  1  one-cycle pulse when the result is updated.
- `min_value`  out  `DATA_W`  selected extreme value (min or max, per `MODE`).
- `min_index`  out  32  element index 0..SCAN_LEN-1 of that value.

## Operation
- The CPU port is a two-state FSM: `IDLE` and `BUSY`, with a latency counter.
- In `IDLE`, a request is accepted when `mem_read` or `mem_write` is sampled high.
  - The FSM latches address, data and type, then enters `BUSY` with count = `LATENCY`.
  - Both requests high: the access is treated as a write; the read is dropped.
- In `BUSY`, request inputs are ignored and the count decrements each cycle.
  - On the final `BUSY` cycle, `ready` = 1.
  - For a write, the array is written at the edge ending that cycle.
  - For a read, `mem_out` presents the latched-address word during that cycle.
  - The FSM returns to `IDLE` at that edge.
- `mem_out` holds its last read value until the next read completes. Writes do not change it.
- The scan engine is an independent FSM: `S_IDLE` and `S_RUN`, with an element counter `k`.
  - It reads through a second, combinational read port.
  - `scan_start` sampled high in `S_IDLE` enters `S_RUN` with k=0 and the accumulator cleared to "no candidate".
  - `scan_start` is ignored in `S_RUN`.
- For each element k = 0..SCAN_LEN-1, the engine compares `mem[SCAN_BASE/4 + k]` against the accumulator and replaces it only on a strictly better value. Ties keep the lowest index. Element 0 always loads.
- After element SCAN_LEN-1, `min_value`/`min_index` load the accumulator, `scan_done` pulses, and the FSM returns to `S_IDLE`. Outputs hold until the next completion.
- A CPU write that commits in the same cycle element k is examined does not affect element k. The scan sees the old value.
- Scan addresses wrap modulo `DEPTH`.

## Timing
- Reset (asynchronous): `ready`=0, `mem_out`=0, `scan_busy`=0, `scan_done`=0, `min_value`=0, `min_index`=0. Both FSMs go to idle.
- Reset mid-operation: a pending access is discarded. A write not yet committed is never written. The scan is aborted and its result is not updated. Array contents are not cleared.
- Access latency:
  - Request sampled at edge E.
  - `ready` is high in the cycle after edge E+LATENCY-1.
  - With LATENCY=1, `ready` is high in the cycle right after acceptance.
- Back-to-back accesses: a request held high through the `ready` cycle is re-accepted at the next edge. The CPU controller must drop requests in its `ready` cycle unless it wants a new access.
- Scan timing:
  - `scan_start` sampled at edge E.
  - `scan_busy` is high for exactly SCAN_LEN cycles, from E to E+SCAN_LEN.
  - `scan_done` and the new outputs appear at edge E+SCAN_LEN and last one cycle.
  - A new `scan_start` is accepted on the `scan_done` cycle.

## Test plan
- LATENCY=3, read word 250 (addr 1000) preloaded 0x1234 → `ready` exactly 3 cycles after acceptance, `mem_out`=0x1234; `ready` low in all other cycles.
- Write 0xDEAD to addr 8, then read addr 8 → second `ready` returns 0xDEAD. Read and write asserted together to addr 12 → acts as a write and `mem_out` is unchanged.
- Scan region {5, -3, 7, -3, 0} with SCAN_LEN=5, SIGNED=1, MODE=0 → after 5 busy cycles, `min_value`=-3 and `min_index`=1. With SIGNED=0, the minimum is 0 at index 4. With MODE=1, SIGNED=1, the result is 7 at index 2.
- Pulse `scan_start` while busy → ignored; `scan_busy` still lasts SCAN_LEN cycles and there is one `scan_done`. During the scan, a CPU write of -100 to an already-scanned element → result unchanged.
- Assert `rst` during `BUSY` of a write and mid-scan → all outputs go to 0 immediately, the target word keeps its old value, and there is no `scan_done`. After release, a new read and scan complete normally.
